lm32_dp_ram_be: RTL and testbench
=================================

// Module: lm32_dp_ram_be
// PURPOSE
//  Simple dual-port RAM (1 write port, 1 read port, single clock) with per-byte
//  write enables, gated synchronous read, optional output pipeline register,
//  selectable read-during-write bypass and a hardware clear-after-reset engine.
//  Drop-in storage for LM32 caches/TLBs/register file, where tag/valid arrays
//  must be zero after reset without software intervention.
// PARAMETERS
//  addr_width     10    width of waddr_i/raddr_i
//  addr_depth     1024  number of words; must be <= 2**addr_width
//  data_width     32    word width; must be a multiple of byte_width
//  byte_width     8     bits per write-enable lane; NB = data_width/byte_width
//  out_reg        0     0: read latency 1; 1: extra output register, latency 2
//  bypass         1     1: same-address read during write returns new data; 0: old
//  clear_on_reset 1     1: zero every word after reset; 0: no clear, ready at once
// PORTS
//  clk_i    in  1           clock, all activity on rising edge
//  rst_n_i  in  1           reset, synchronous, active-low
//  we_i     in  1           write request
//  be_i     in  NB          byte-lane write enables, bit b covers wdata_i[b*byte_width +: byte_width]
//  waddr_i  in  addr_width  write address
//  wdata_i  in  data_width  write data
//  re_i     in  1           read request
//  raddr_i  in  addr_width  read address
//  rdata_o  out data_width  read data
//  rvalid_o out 1           rdata_o carries result of a read request this cycle
//  busy_o   out 1           clear engine running; requests ignored
// BEHAVIOUR
//  Reset (rst_n_i=0 at edge): rdata_o=0, rvalid_o=0, pipeline regs=0, clear
//   counter=0, state=CLEAR if clear_on_reset else READY; busy_o=1 in CLEAR.
//   RAM contents not touched by reset itself.
//  FSM: CLEAR -> READY. CLEAR writes zero to word cnt each cycle, cnt 0..addr_depth-1;
//   on the cycle writing addr_depth-1 next state READY. busy_o=1 for exactly
//   addr_depth cycles after reset release. Reset during CLEAR restarts at cnt=0.
//  While busy_o=1: we_i and re_i ignored; rvalid_o=0; rdata_o holds 0.
//  Write (READY, we_i=1): lanes with be_i[b]=1 updated at the edge; other lanes kept.
//   be_i=0 is a no-op. waddr_i >= addr_depth: write dropped, no alias.
//  Read (READY, re_i=1 at edge N): out_reg=0 -> rdata_o valid and rvalid_o=1 in
//   cycle N+1; out_reg=1 -> cycle N+2. rvalid_o is a 1-cycle pulse per request;
//   back-to-back reads give one result per cycle. re_i=0: rdata_o holds last value,
//   rvalid_o=0. raddr_i >= addr_depth: rdata_o=0 with rvalid_o=1.
//  Collision (we_i & re_i, waddr_i==raddr_i, same edge): bypass=1 -> enabled lanes
//   return wdata_i, disabled lanes return stored data; bypass=0 -> all old data.
//   Write at N, read of same address at N+1 always sees new data.
//  Pipeline: out_reg=1 stage shifts data and valid together; reset clears both.
// TESTING
//  1 rst_n_i low 2 cycles, release, depth=16 -> busy_o=1 exactly 16 cycles; then
//    read all 16 addresses -> every rdata_o=0, rvalid_o=1 one cycle after each re_i.
//  2 write 0xDEADBEEF be=4'b1111 to 5, then 0x00000011 be=4'b0001 to 5; read 5 ->
//    0xDEADBE11.
//  3 collision: addr 7 holds 0x11111111, write 0x22222222 be=4'b0011 + read 7 same
//    edge -> bypass=1: 0x11112222; bypass=0: 0x11111111; next read 0x11112222.
//  4 out_reg=1: re_i pulses at N, N+1 on addr 1,2 -> rvalid_o at N+2, N+3 with data
//    in order; re_i low afterwards -> rdata_o held, rvalid_o=0.
//  5 reset asserted mid-CLEAR (cnt=8) after writing nonzero data -> clear restarts,
//    busy_o=1 for full addr_depth cycles, we_i/re_i during busy ignored, all words 0.
//  6 waddr_i=addr_depth write 0xFFFFFFFF (addr_width wider than needed) -> no word
//    changes; read of addr_depth -> 0, rvalid_o=1.

Source files
------------

// File: rtl/lm32_dp_ram_be.sv
// Simple dual-port RAM with byte-lane write enables, synchronous gated read,
// optional output register, selectable read-during-write bypass and a post-reset clear engine.
module lm32_dp_ram_be #(
  parameter int addr_width     = 10,
  parameter int addr_depth     = 1024,
  parameter int data_width     = 32,
  parameter int byte_width     = 8,
  parameter int out_reg        = 0,
  parameter int bypass         = 1,
  parameter int clear_on_reset = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 we_i,
  input  logic [data_width/byte_width-1:0]     be_i,
  input  logic [addr_width-1:0]                waddr_i,
  input  logic [data_width-1:0]                wdata_i,
  input  logic                                 re_i,
  input  logic [addr_width-1:0]                raddr_i,
  output logic [data_width-1:0]                rdata_o,
  output logic                                 rvalid_o,
  output logic                                 busy_o
);

  localparam int NB       = data_width / byte_width;
  localparam int IDX_W    = (addr_depth > 1) ? $clog2(addr_depth) : 1;
  localparam int LAST_INT = addr_depth - 1;
  localparam logic [addr_width:0]   DEPTH = addr_depth[addr_width:0];
  localparam logic [addr_width-1:0] LAST  = LAST_INT[addr_width-1:0];

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                  state_q, state_d;
  logic [addr_width-1:0]   cnt_q, cnt_d;
  logic [data_width-1:0]   rdata1_q, rdata1_d;
  logic                    rvalid1_q, rvalid1_d;
  logic [data_width-1:0]   rdata2_q, rdata2_d;
  logic                    rvalid2_q, rvalid2_d;

  logic [data_width-1:0]   mem [addr_depth];

  logic                    busy;
  logic                    clr_we;
  logic                    wr_fire;
  logic                    rd_fire;
  logic                    rd_in_range;
  logic [data_width-1:0]   rd_word;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy        = (state_q == ST_CLEAR);
    clr_we      = busy && rst_n_i;
    wr_fire     = !busy && rst_n_i && we_i && ({1'b0, waddr_i} < DEPTH);
    rd_fire     = !busy && rst_n_i && re_i;
    rd_in_range = ({1'b0, raddr_i} < DEPTH);
    rd_word     = '0;

    if (busy) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end
    end

    if (rd_in_range) begin
      rd_word = mem[raddr_i[IDX_W-1:0]];
    end
    // Same-edge collision: mem still holds the old word, so merge the enabled lanes here.
    if ((bypass != 0) && wr_fire && (waddr_i == raddr_i)) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          rd_word[b*byte_width +: byte_width] = wdata_i[b*byte_width +: byte_width];
        end
      end
    end

    rdata1_d  = rd_fire ? rd_word : rdata1_q;
    rvalid1_d = rd_fire;
    rdata2_d  = rvalid1_q ? rdata1_q : rdata2_q;
    rvalid2_d = rvalid1_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= (clear_on_reset != 0) ? ST_CLEAR : ST_READY;
      cnt_q     <= '0;
      rdata1_q  <= '0;
      rvalid1_q <= 1'b0;
      rdata2_q  <= '0;
      rvalid2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata1_q  <= rdata1_d;
      rvalid1_q <= rvalid1_d;
      rdata2_q  <= rdata2_d;
      rvalid2_q <= rvalid2_d;
    end
  end

  // Storage has no reset; the clear engine zeroes it instead.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[cnt_q[IDX_W-1:0]] <= '0;
    end else if (wr_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          mem[waddr_i[IDX_W-1:0]][b*byte_width +: byte_width] <= wdata_i[b*byte_width +: byte_width];
        end
      end
    end
  end

  assign rdata_o  = (out_reg != 0) ? rdata2_q  : rdata1_q;
  assign rvalid_o = (out_reg != 0) ? rvalid2_q : rvalid1_q;
  assign busy_o   = busy;

endmodule

// File: tb/tb_lm32_dp_ram_be.sv
// Scoreboard bench: three instances (bypass on, bypass off, output register) share
// stimulus; each read pushes the expected word and arrival cycle, monitors pop on rvalid_o.
module tb_lm32_dp_ram_be;

  localparam int AW = 5;
  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] d;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [3:0]  be;
  logic [AW-1:0] waddr;
  logic [31:0] wdata;
  logic        re;
  logic [AW-1:0] raddr;

  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        rvalid_a, rvalid_b, rvalid_c;
  logic        busy_a, busy_b, busy_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t sb_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lm32_dp_ram_be #(.addr_width(AW), .addr_depth(DEPTH), .data_width(32), .byte_width(8),
                   .out_reg(0), .bypass(1), .clear_on_reset(1)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .be_i(be), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata_a), .rvalid_o(rvalid_a), .busy_o(busy_a));

  lm32_dp_ram_be #(.addr_width(AW), .addr_depth(DEPTH), .data_width(32), .byte_width(8),
                   .out_reg(0), .bypass(0), .clear_on_reset(1)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .be_i(be), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata_b), .rvalid_o(rvalid_b), .busy_o(busy_b));

  lm32_dp_ram_be #(.addr_width(AW), .addr_depth(DEPTH), .data_width(32), .byte_width(8),
                   .out_reg(1), .bypass(1), .clear_on_reset(1)) dut_c (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .be_i(be), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata_c), .rvalid_o(rvalid_c), .busy_o(busy_c));

  // Monitors: sample 1 time unit after the rising edge.
  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      if (rvalid_a) begin
        checks++;
        if (sb_a.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid dut_a cycle %0d data %h", cyc, rdata_a);
        end else begin
          e = sb_a.pop_front();
          if (rdata_a !== e.d || cyc != e.t) begin
            errors++;
            $display("FAIL read_a got %h at cycle %0d, want %h at cycle %0d", rdata_a, cyc, e.d, e.t);
          end
        end
      end
      if (rvalid_b) begin
        checks++;
        if (sb_b.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid dut_b cycle %0d data %h", cyc, rdata_b);
        end else begin
          e = sb_b.pop_front();
          if (rdata_b !== e.d || cyc != e.t) begin
            errors++;
            $display("FAIL read_b got %h at cycle %0d, want %h at cycle %0d", rdata_b, cyc, e.d, e.t);
          end
        end
      end
      if (rvalid_c) begin
        checks++;
        if (sb_c.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid dut_c cycle %0d data %h", cyc, rdata_c);
        end else begin
          e = sb_c.pop_front();
          if (rdata_c !== e.d || cyc != e.t) begin
            errors++;
            $display("FAIL read_c got %h at cycle %0d, want %h at cycle %0d", rdata_c, cyc, e.d, e.t);
          end
        end
      end
      if (sb_a.size() > 0 && sb_a[0].t < cyc) begin
        e = sb_a.pop_front();
        checks++; errors++;
        $display("FAIL missing_rvalid dut_a got none at cycle %0d, want %h", e.t, e.d);
      end
      if (sb_b.size() > 0 && sb_b[0].t < cyc) begin
        e = sb_b.pop_front();
        checks++; errors++;
        $display("FAIL missing_rvalid dut_b got none at cycle %0d, want %h", e.t, e.d);
      end
      if (sb_c.size() > 0 && sb_c[0].t < cyc) begin
        e = sb_c.pop_front();
        checks++; errors++;
        $display("FAIL missing_rvalid dut_c got none at cycle %0d, want %h", e.t, e.d);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; a read pushes e_new (bypass instances) and e_old (no-bypass instance).
  task automatic op(input logic w, input logic [3:0] b, input logic [AW-1:0] wa,
                    input logic [31:0] wd, input logic r, input logic [AW-1:0] ra,
                    input logic [31:0] e_new, input logic [31:0] e_old);
    exp_t e;
    @(negedge clk);
    we = w; be = b; waddr = wa; wdata = wd; re = r; raddr = ra;
    if (r) begin
      e.d = e_new; e.t = cyc + 1; sb_a.push_back(e);
      e.d = e_old; e.t = cyc + 1; sb_b.push_back(e);
      e.d = e_new; e.t = cyc + 2; sb_c.push_back(e);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
    op(1'b1, b, a, d, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] e);
    op(1'b0, 4'h0, '0, '0, 1'b1, a, e, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      we = 1'b0; re = 1'b0; be = 4'h0;
    end
  endtask

  // Called at a negedge right after reset release; drives ignored junk while busy.
  task automatic count_busy(input logic junk, output int n);
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      we = junk; re = junk; be = 4'hF; wdata = 32'hFFFF_FFFF;
      waddr = AW'(n % DEPTH); raddr = AW'(n % DEPTH);
      @(negedge clk);
    end
    we = 1'b0; re = 1'b0; be = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; we = 1'b0; re = 1'b0; be = 4'h0; waddr = '0; raddr = '0; wdata = '0;

    // Test 1: reset state, busy length, memory cleared.
    @(negedge clk); @(negedge clk);
    chk("reset_rdata_a", rdata_a, 32'h0);
    chk("reset_rdata_c", rdata_c, 32'h0);
    chk("reset_rvalid", {29'b0, rvalid_a, rvalid_b, rvalid_c}, 32'h0);
    chk("reset_busy", {29'b0, busy_a, busy_b, busy_c}, 32'h7);
    mon_en = 1'b1;
    rst_n = 1'b1;
    count_busy(1'b0, n);
    chk("busy_cycles", n, DEPTH);
    chk("busy_done_all", {29'b0, busy_a, busy_b, busy_c}, 32'h0);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i), 32'h0);
    idle(3);

    // Test 2: byte-lane merge, be=0 no-op, write-then-read next cycle.
    wr(5, 32'hDEAD_BEEF, 4'b1111);
    wr(5, 32'h0000_0011, 4'b0001);
    rd(5, 32'hDEAD_BE11);
    wr(5, 32'h5555_5555, 4'b0000);
    rd(5, 32'hDEAD_BE11);

    // Test 3: same-edge collision.
    wr(7, 32'h1111_1111, 4'b1111);
    op(1'b1, 4'b0011, 7, 32'h2222_2222, 1'b1, 7, 32'h1111_2222, 32'h1111_1111);
    rd(7, 32'h1111_2222);
    idle(3);

    // Test 4: back-to-back reads, then hold.
    wr(1, 32'hA1A1_A1A1, 4'b1111);
    wr(2, 32'hB2B2_B2B2, 4'b1111);
    rd(1, 32'hA1A1_A1A1);
    rd(2, 32'hB2B2_B2B2);
    idle(4);
    chk("hold_rdata_c", rdata_c, 32'hB2B2_B2B2);
    chk("hold_rdata_a", rdata_a, 32'hB2B2_B2B2);
    chk("hold_rvalid", {29'b0, rvalid_a, rvalid_b, rvalid_c}, 32'h0);

    // Test 6: out-of-range write dropped, out-of-range read returns zero.
    wr(AW'(DEPTH), 32'hFFFF_FFFF, 4'b1111);
    rd(AW'(DEPTH), 32'h0);
    rd(0, 32'h0);
    rd(5, 32'hDEAD_BE11);
    rd(AW'(DEPTH + 7), 32'h0);
    idle(3);

    // Test 5: reset mid-clear restarts the clear.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; re = 1'b1; be = 4'hF; wdata = 32'hFFFF_FFFF;
      waddr = AW'(15 - i); raddr = AW'(i);
      @(negedge clk);
    end
    chk("mid_clear_busy", {31'b0, busy_a}, 32'h1);
    rst_n = 1'b0; we = 1'b0; re = 1'b0;
    @(negedge clk);
    chk("mid_clear_reset_rdata_a", rdata_a, 32'h0);
    rst_n = 1'b1;
    count_busy(1'b1, n);
    chk("busy_cycles_restart", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i), 32'h0);
    idle(5);

    checks++;
    if (sb_a.size() + sb_b.size() + sb_c.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", sb_a.size() + sb_b.size() + sb_c.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
